// File: rtl/stack_alu_pkg.sv
// Shared definitions for stack_alu: 4-bit opcodes, error codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package stack_alu_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LIT  = 4'd1;
   localparam logic [3:0] OP_DUP  = 4'd2;
   localparam logic [3:0] OP_DROP = 4'd3;
   localparam logic [3:0] OP_SWAP = 4'd4;
   localparam logic [3:0] OP_OVER = 4'd5;
   localparam logic [3:0] OP_ADD  = 4'd6;
   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_UNDER = 2'd1,
      ERR_OVER  = 2'd2,
      ERR_BADOP = 2'd3
   } err_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_FILL = 1'b1
   } state_e;

endpackage

// File: rtl/stack_alu_if.sv
// Command channel into stack_alu: opcode plus literal, valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: op_ready from the slave gates acceptance; master holds op/imm while op_valid is high.
// Signals: op_valid, op, imm (master -> slave); op_ready (slave -> master).
interface stack_alu_if #(
   parameter int WIDTH = 32
) ();
   logic             op_valid;
   logic             op_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] imm;

   modport master (output op_valid, output op, output imm, input  op_ready);
   modport slave  (input  op_valid, input  op, input  imm, output op_ready);
endinterface

// File: rtl/stack_alu_fn.sv
// Combinational binary function unit: y = a op b for ADD/SUB/AND/OR/XOR, modulo 2^WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op (opcode), a (second item, N), b (top item, T), y (result; 0 for non-ALU opcodes).
module stack_alu_fn
   import stack_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/stack_alu.sv
// Forth-style T/N register stage that spills N to and refills N from an attached stack memory.
// Latency: results visible the cycle after acceptance; refilling pops add one FILL cycle.
// Backpressure: op_ready drops for exactly one cycle while N is refilled from q.
// Ports: clk, reset (async active-low); cmd (op/imm handshake); tos/nos/depth/err/err_code status;
//        push/pop/d to the stack and q back from it (q valid the cycle after pop).
module stack_alu
   import stack_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 3)
) (
   input  logic             clk,
   input  logic             reset,
   stack_alu_if.slave       cmd,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CNT_W-1:0] depth,
   output logic             err,
   output logic [1:0]       err_code,
   output logic             push,
   output logic             pop,
   output logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] q
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH + 2);
   localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);

   state_e           state;
   err_e             code;
   logic             is_push;
   logic             is_pop;
   logic [1:0]       need;
   logic             bad;
   logic             accept;
   logic             op_err;
   logic             exec;
   logic [WIDTH-1:0] fn_y;

   stack_alu_fn #(.WIDTH(WIDTH)) u_fn (
      .op (cmd.op),
      .a  (nos),
      .b  (tos),
      .y  (fn_y)
   );

   // Classify the opcode and work out whether executing it now would fault.
   always_comb begin
      is_push = 1'b0;
      is_pop  = 1'b0;
      need    = 2'd0;
      bad     = 1'b0;
      case (cmd.op)
         OP_NOP:                                 ;
         OP_LIT, OP_DUP:                         is_push = 1'b1;
         OP_OVER: begin                          is_push = 1'b1; need = 2'd2; end
         OP_DROP: begin                          is_pop  = 1'b1; need = 2'd1; end
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin is_pop = 1'b1; need = 2'd2; end
         OP_SWAP:                                need    = 2'd2;
         default:                                bad     = 1'b1;
      endcase
      code = ERR_NONE;
      if (bad)                                code = ERR_BADOP;
      else if (depth < CNT_W'(need))          code = ERR_UNDER;
      else if (is_push && (depth == FULL))    code = ERR_OVER;
   end

   assign cmd.op_ready = (state == ST_RUN);
   assign accept       = cmd.op_valid & cmd.op_ready;
   assign op_err       = accept & (code != ERR_NONE);
   assign exec         = accept & ~op_err;

   // The stack samples these on the same edge the op commits. Gated by reset so the
   // memory sees no traffic while held in reset. Pop only when memory is non-empty (depth > 2).
   assign push = reset & exec & is_push & (depth >= TWO);
   assign pop  = reset & exec & is_pop  & (depth >  TWO);
   assign d    = nos;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_RUN;
         tos      <= '0;
         nos      <= '0;
         depth    <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         case (state)
            ST_FILL: begin
               nos   <= q;
               state <= ST_RUN;
            end
            default: begin
               if (op_err) begin
                  // First error is kept until reset.
                  if (!err) begin
                     err      <= 1'b1;
                     err_code <= code;
                  end
               end else if (exec) begin
                  case (cmd.op)
                     OP_LIT: begin
                        nos   <= tos;
                        tos   <= cmd.imm;
                        depth <= depth + CNT_W'(1);
                     end
                     OP_DUP: begin
                        nos   <= tos;
                        depth <= depth + CNT_W'(1);
                     end
                     OP_OVER: begin
                        tos   <= nos;
                        nos   <= tos;
                        depth <= depth + CNT_W'(1);
                     end
                     OP_SWAP: begin
                        tos <= nos;
                        nos <= tos;
                     end
                     OP_DROP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        tos   <= (cmd.op == OP_DROP) ? nos : fn_y;
                        depth <= depth - CNT_W'(1);
                        // N comes back from memory next cycle, or reads 0 once depth falls below 2.
                        if (depth > TWO) state <= ST_FILL;
                        else             nos   <= '0;
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_alu.sv
// Bench for stack_alu (WIDTH=32, DEPTH=4) with a 1-cycle-read stack memory model.
// Stimulus queues expected T/N/depth/err and stack traffic; a negedge monitor checks them.
// Reset behaviour, including reset asserted mid-FILL, is checked directly.
module tb_stack_alu;
   import stack_alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] tos, nos, d, q;
   logic [2:0]  depth;
   logic        err, push, pop;
   logic [1:0]  err_code;

   stack_alu_if #(.WIDTH(32)) ifc ();

   stack_alu #(.WIDTH(32), .DEPTH(4)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .cmd      (ifc),
      .tos      (tos),
      .nos      (nos),
      .depth    (depth),
      .err      (err),
      .err_code (err_code),
      .push     (push),
      .pop      (pop),
      .d        (d),
      .q        (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stack memory: push stores d, pop presents the top on q next cycle.
   logic [31:0] mem [0:7];
   logic [2:0]  sp;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= 3'd0;
         q  <= 32'd0;
      end else if (push) begin
         mem[sp] <= d;
         sp      <= sp + 3'd1;
      end else if (pop) begin
         q  <= mem[sp - 3'd1];
         sp <= sp - 3'd1;
      end
   end

   typedef struct {
      string       name;
      logic [31:0] t;
      logic [31:0] n;
      logic [2:0]  dep;
      logic        e;
      logic [1:0]  ec;
      int          fill;
   } exp_t;

   typedef struct {
      logic        is_push;
      logic [31:0] dat;
   } trf_t;

   exp_t sbq[$];
   trf_t tq[$];
   int   tests = 0;
   int   fails = 0;
   bit   pend  = 1'b0;
   int   fill_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] v);
      trf_t r;
      r.is_push = 1'b1;
      r.dat     = v;
      tq.push_back(r);
   endtask

   task automatic exp_pop();
      trf_t r;
      r.is_push = 1'b0;
      r.dat     = 32'd0;
      tq.push_back(r);
   endtask

   // Issue one command at posedge+1; returns at posedge+1 after acceptance.
   task automatic do_op(input string nm, input logic [3:0] o, input logic [31:0] i, input bit rec,
                        input logic [31:0] et, input logic [31:0] en, input logic [2:0] ed,
                        input logic ee, input logic [1:0] eec, input int ef);
      exp_t e;
      int   n = 0;
      while (!ifc.op_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({nm, ".ready_wait"}, 32'(ifc.op_ready), 32'd1);
      if (rec) begin
         e.name = nm; e.t = et; e.n = en; e.dep = ed; e.e = ee; e.ec = eec; e.fill = ef;
         sbq.push_back(e);
      end
      ifc.op_valid = 1'b1;
      ifc.op       = o;
      ifc.imm      = i;
      @(posedge clk); #1;
      ifc.op_valid = 1'b0;
      ifc.op       = OP_NOP;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".tos"},      tos,                  32'd0);
      chk({tag, ".nos"},      nos,                  32'd0);
      chk({tag, ".depth"},    32'(depth),           32'd0);
      chk({tag, ".err"},      32'(err),             32'd0);
      chk({tag, ".err_code"}, 32'(err_code),        32'd0);
      chk({tag, ".push"},     32'(push),            32'd0);
      chk({tag, ".pop"},      32'(pop),             32'd0);
      chk({tag, ".op_ready"}, 32'(ifc.op_ready),    32'd1);
   endtask

   task automatic do_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: checks stack traffic as it is presented, and the resulting state once each op completes.
   always @(negedge clk) begin
      exp_t e;
      trf_t r;
      if (!rst_n) begin
         pend     = 1'b0;
         fill_cnt = 0;
      end else begin
         if (push || pop) begin
            chk("traffic_expected", 32'(tq.size() > 0), 32'd1);
            if (tq.size() > 0) begin
               r = tq.pop_front();
               chk("traffic_kind_push", 32'(push), 32'(r.is_push));
               if (push) chk("push_d", d, r.dat);
            end
         end
         if (pend && !ifc.op_ready) begin
            fill_cnt++;
         end else if (pend) begin
            pend = 1'b0;
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk({e.name, ".tos"},      tos,             e.t);
               chk({e.name, ".nos"},      nos,             e.n);
               chk({e.name, ".depth"},    32'(depth),      32'(e.dep));
               chk({e.name, ".err"},      32'(err),        32'(e.e));
               chk({e.name, ".err_code"}, 32'(err_code),   32'(e.ec));
               chk({e.name, ".fill_cyc"}, 32'(fill_cnt),   32'(e.fill));
            end
         end
         if (ifc.op_valid && ifc.op_ready) begin
            pend     = 1'b1;
            fill_cnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      ifc.op_valid = 1'b0;
      ifc.op       = OP_NOP;
      ifc.imm      = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Add without memory traffic.
      do_op("lit5",  OP_LIT,  32'd5, 1, 32'd5,  32'd0, 3'd1, 0, 2'd0, 0);
      do_op("lit7",  OP_LIT,  32'd7, 1, 32'd7,  32'd5, 3'd2, 0, 2'd0, 0);
      do_op("add12", OP_ADD,  32'd0, 1, 32'd12, 32'd0, 3'd1, 0, 2'd0, 0);
      do_op("drop0", OP_DROP, 32'd0, 1, 32'd0,  32'd0, 3'd0, 0, 2'd0, 0);

      // Spill 1,2,3 then refill on DROP.
      do_op("l1", OP_LIT, 32'd1, 1, 32'd1, 32'd0, 3'd1, 0, 2'd0, 0);
      do_op("l2", OP_LIT, 32'd2, 1, 32'd2, 32'd1, 3'd2, 0, 2'd0, 0);
      exp_push(32'd1);
      do_op("l3", OP_LIT, 32'd3, 1, 32'd3, 32'd2, 3'd3, 0, 2'd0, 0);
      exp_push(32'd2);
      do_op("l4", OP_LIT, 32'd4, 1, 32'd4, 32'd3, 3'd4, 0, 2'd0, 0);
      exp_push(32'd3);
      do_op("l5", OP_LIT, 32'd5, 1, 32'd5, 32'd4, 3'd5, 0, 2'd0, 0);
      exp_pop();
      do_op("drop_fill", OP_DROP, 32'd0, 1, 32'd4, 32'd3, 3'd4, 0, 2'd0, 1);

      // Fill to capacity, then overflow; later ops still execute, first error sticks.
      exp_push(32'd3);
      do_op("l6", OP_LIT, 32'd6, 1, 32'd6, 32'd4, 3'd5, 0, 2'd0, 0);
      exp_push(32'd4);
      do_op("l8", OP_LIT, 32'd8, 1, 32'd8, 32'd6, 3'd6, 0, 2'd0, 0);
      do_op("ovf", OP_LIT, 32'd9, 1, 32'd8, 32'd6, 3'd6, 1, 2'd2, 0);
      exp_pop();
      do_op("drop_after_ovf", OP_DROP, 32'd0, 1, 32'd6, 32'd4, 3'd5, 1, 2'd2, 1);
      exp_pop();
      do_op("add_fill", OP_ADD, 32'd0, 1, 32'd10, 32'd3, 3'd4, 1, 2'd2, 1);
      do_op("badop_sticky", 4'hF, 32'd0, 1, 32'd10, 32'd3, 3'd4, 1, 2'd2, 0);

      // Underflow from empty.
      do_reset();
      do_op("under_drop", OP_DROP, 32'd0, 1, 32'd0, 32'd0, 3'd0, 1, 2'd1, 0);

      // Wrapping arithmetic and the remaining stack ops.
      do_reset();
      do_op("w3",    OP_LIT, 32'd3,          1, 32'd3,          32'd0, 3'd1, 0, 2'd0, 0);
      do_op("wff",   OP_LIT, 32'hFFFF_FFFF,  1, 32'hFFFF_FFFF,  32'd3, 3'd2, 0, 2'd0, 0);
      do_op("wadd",  OP_ADD, 32'd0,          1, 32'd2,          32'd0, 3'd1, 0, 2'd0, 0);
      do_op("wdrop", OP_DROP, 32'd0,         1, 32'd0,          32'd0, 3'd0, 0, 2'd0, 0);
      do_op("s2",    OP_LIT, 32'd2,          1, 32'd2,          32'd0, 3'd1, 0, 2'd0, 0);
      do_op("s5",    OP_LIT, 32'd5,          1, 32'd5,          32'd2, 3'd2, 0, 2'd0, 0);
      do_op("sub",   OP_SUB, 32'd0,          1, 32'hFFFF_FFFD,  32'd0, 3'd1, 0, 2'd0, 0);
      do_op("dup",   OP_DUP, 32'd0,          1, 32'hFFFF_FFFD,  32'hFFFF_FFFD, 3'd2, 0, 2'd0, 0);
      exp_push(32'hFFFF_FFFD);
      do_op("l7",    OP_LIT, 32'd7,          1, 32'd7,          32'hFFFF_FFFD, 3'd3, 0, 2'd0, 0);
      exp_push(32'hFFFF_FFFD);
      do_op("over",  OP_OVER, 32'd0,         1, 32'hFFFF_FFFD,  32'd7, 3'd4, 0, 2'd0, 0);
      do_op("swap",  OP_SWAP, 32'd0,         1, 32'd7,          32'hFFFF_FFFD, 3'd4, 0, 2'd0, 0);
      exp_pop();
      do_op("xor",   OP_XOR, 32'd0,          1, 32'hFFFF_FFFA,  32'hFFFF_FFFD, 3'd3, 0, 2'd0, 1);
      exp_pop();
      do_op("and",   OP_AND, 32'd0,          1, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 3'd2, 0, 2'd0, 1);
      do_op("or",    OP_OR,  32'd0,          1, 32'hFFFF_FFFD,  32'd0, 3'd1, 0, 2'd0, 0);
      do_op("nop",   OP_NOP, 32'd0,          1, 32'hFFFF_FFFD,  32'd0, 3'd1, 0, 2'd0, 0);
      do_op("swap_under", OP_SWAP, 32'd0,    1, 32'hFFFF_FFFD,  32'd0, 3'd1, 1, 2'd1, 0);

      // Reset asserted during the FILL cycle.
      do_reset();
      do_op("r1", OP_LIT, 32'd1, 1, 32'd1, 32'd0, 3'd1, 0, 2'd0, 0);
      do_op("r2", OP_LIT, 32'd2, 1, 32'd2, 32'd1, 3'd2, 0, 2'd0, 0);
      exp_push(32'd1);
      do_op("r3", OP_LIT, 32'd3, 1, 32'd3, 32'd2, 3'd3, 0, 2'd0, 0);
      exp_pop();
      do_op("rdrop", OP_DROP, 32'd0, 0, 32'd0, 32'd0, 3'd0, 0, 2'd0, 0);
      chk("fill_state.op_ready", 32'(ifc.op_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset("reset_in_fill");
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      do_op("after_rst", OP_LIT, 32'd1, 1, 32'd1, 32'd0, 3'd1, 0, 2'd0, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      chk("traffic_drained",    32'(tq.size()),  32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
